// File: rtl/wb_slave_mem_if.sv
// Point-to-point Wishbone classic bus between one initiator and one responder.
// Signal suffixes are named from the responder's side.
interface wb_slave_mem_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  cyc_i;
    logic                  stb_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack_o;
    logic                  err_o;

    modport slave  (input  cyc_i, stb_i, we_i, adr_i, dat_i,
                    output dat_o, ack_o, err_o);
    modport master (output cyc_i, stb_i, we_i, adr_i, dat_i,
                    input  dat_o, ack_o, err_o);
endinterface

// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle responder backed by a register array, with
// configurable wait states and err_o termination for out-of-window addresses.
module wb_slave_mem #(
    parameter int unsigned BASE_ADDRESS = 0,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DATA_COUNT   = 16,
    parameter int unsigned AU_IN_DATA   = 1,
    parameter int unsigned WAIT_STATES  = 0
) (
    input  logic         clk,
    input  logic         rst,
    wb_slave_mem_if.slave wb
);
    localparam int unsigned EXT_W = ADDR_WIDTH + 1;
    localparam int unsigned IDX_W = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1;
    localparam int unsigned CNT_W = 4;
    localparam logic [EXT_W-1:0] BASE_EXT  = EXT_W'(BASE_ADDRESS);
    localparam logic [EXT_W-1:0] AU_EXT    = EXT_W'(AU_IN_DATA);
    localparam logic [EXT_W-1:0] COUNT_EXT = EXT_W'(DATA_COUNT);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic                   valid_q, valid_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  wdat_q, wdat_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [DATA_WIDTH-1:0]  dat_q, dat_d;
    logic [DATA_WIDTH-1:0]  mem_q [DATA_COUNT];

    logic [EXT_W-1:0]       off_c, idx_full_c;
    logic                   dec_valid_c, req_c;
    logic                   sel_we_c, sel_valid_c;
    logic [IDX_W-1:0]       sel_idx_c;
    logic [DATA_WIDTH-1:0]  sel_dat_c;
    logic                   fire_c, mem_we_c;

    // Borrow out of the widened subtraction marks an address below the base.
    assign off_c       = {1'b0, wb.adr_i} - BASE_EXT;
    assign idx_full_c  = off_c / AU_EXT;
    assign dec_valid_c = !off_c[EXT_W-1] && ((off_c % AU_EXT) == '0) && (idx_full_c < COUNT_EXT);
    assign req_c       = wb.cyc_i & wb.stb_i;

    // In S_IDLE a zero-wait request terminates straight from the live bus.
    assign sel_we_c    = (state_q == S_IDLE) ? wb.we_i           : we_q;
    assign sel_valid_c = (state_q == S_IDLE) ? dec_valid_c       : valid_q;
    assign sel_idx_c   = (state_q == S_IDLE) ? IDX_W'(idx_full_c) : idx_q;
    assign sel_dat_c   = (state_q == S_IDLE) ? wb.dat_i          : wdat_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        wdat_d   = wdat_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = dat_q;
        fire_c   = 1'b0;
        mem_we_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_c) begin
                    we_d    = wb.we_i;
                    valid_d = dec_valid_c;
                    idx_d   = IDX_W'(idx_full_c);
                    wdat_d  = wb.dat_i;
                    if (WAIT_STATES == 0) begin
                        fire_c  = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!wb.cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    fire_c  = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK:     state_d = S_RELEASE;
            S_RELEASE: if (!wb.stb_i) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (fire_c) begin
            if (sel_valid_c) begin
                ack_d    = 1'b1;
                mem_we_c = sel_we_c;
                if (!sel_we_c) dat_d = mem_q[sel_idx_c];
            end else begin
                err_d = 1'b1;
                dat_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            wdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DATA_COUNT; i++) mem_q[i] <= '0;
        end else if (mem_we_c) begin
            mem_q[sel_idx_c] <= sel_dat_c;
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.err_o = err_q;
    assign wb.dat_o = dat_q;
endmodule
